multicycle_ctrl: RTL and testbench

- Multi-cycle successor to the single-cycle RV32I control unit.
- Sequences each instruction through FETCH/DECODE/EXECUTE/WRITEBACK states over a shared memory port, with a wait-state handshake and a bus timeout.
- Resolves the full RV32I branch set and widens the ALU control bus.
- Sits between the instruction register / ALU flags and the multi-cycle datapath muxes and enables.

---
 rtl/multicycle_ctrl_pkg.sv | 64 ++++++
 rtl/multicycle_ctrl_alu_decoder.sv | 35 +++
 rtl/multicycle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
// Opcodes, datapath mux selects, ALU codes and FSM states.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_EXEC_I = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_JAL    = 4'd9;
  localparam logic [3:0] S_JALR   = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_LUI    = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  typedef enum logic [1:0] {
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_FUNCT
  } alu_op_e;

  function automatic logic is_shift(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU control decode from funct fields and state class.
// Shift encodings are unsupported and reported via bad_funct.
module mc_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op5,
  output logic [2:0] alu_ctrl,
  output logic       bad_funct
);

  assign bad_funct = is_shift(funct3);

  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      ALU_OP_SUB: alu_ctrl = ALU_SUB;
      ALU_OP_FUNCT: begin
        unique case (funct3)
          3'b000:  alu_ctrl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with memory wait-state handshake,
// bus timeout and sticky bus/illegal-instruction flags.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 Zero,
  input  logic                 Lt,
  input  logic                 Ltu,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUCtrl,
  output logic                 RegWrite,
  output logic                 bus_err,
  output logic                 illegal
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  logic [3:0]    state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic          bus_err_q, illegal_q, set_ill;
  logic          mem_st, ready, timeout;
  logic          take, br_bad, bad_funct;
  alu_op_e       alu_op;
  logic [2:0]    alu3;

  assign mem_st  = (state == S_FETCH) || (state == S_MEMRD) ||
                   (state == S_MEMWR);
  assign ready   = !MEM_HANDSHAKE || mem_ready;
  assign timeout = mem_st && !ready && (wait_cnt == CNT_LAST);
  assign br_bad  = funct3[2:1] == 2'b01;

  always_comb begin
    take = 1'b0;
    unique case (funct3)
      3'b000:  take = Zero;
      3'b001:  take = !Zero;
      3'b100:  take = Lt;
      3'b101:  take = !Lt;
      3'b110:  take = Ltu;
      3'b111:  take = !Ltu;
      default: take = 1'b0;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .op5      (opcode[5]),
    .alu_ctrl (alu3),
    .bad_funct(bad_funct)
  );

  always_comb begin
    state_nx = state;
    set_ill  = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (timeout)    state_nx = S_TRAP;
        else if (ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_R: begin
            state_nx = bad_funct ? S_TRAP : S_EXEC_R;
            set_ill  = bad_funct;
          end
          OP_I: begin
            state_nx = bad_funct ? S_TRAP : S_EXEC_I;
            set_ill  = bad_funct;
          end
          OP_JAL:    state_nx = S_JAL;
          OP_JALR:   state_nx = S_JALR;
          OP_BRANCH: state_nx = S_BRANCH;
          OP_LUI:    state_nx = S_LUI;
          default: begin
            state_nx = S_TRAP;
            set_ill  = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_nx = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (timeout)    state_nx = S_TRAP;
        else if (ready) state_nx = S_MEMWB;
      end
      S_MEMWR: begin
        if (timeout)    state_nx = S_TRAP;
        else if (ready) state_nx = S_FETCH;
      end
      S_MEMWB, S_ALUWB: state_nx = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_JALR, S_LUI: state_nx = S_ALUWB;
      S_BRANCH: begin
        state_nx = br_bad ? S_TRAP : S_FETCH;
        set_ill  = br_bad;
      end
      default: state_nx = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nx;
      bus_err_q <= bus_err_q | timeout;
      illegal_q <= illegal_q | set_ill;
      if (state_nx != state || !mem_st) wait_cnt <= '0;
      else                              wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Everything is held low while rst_n is low, even though FETCH is not.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ImmSrc    = IMM_I;
    RegWrite  = 1'b0;
    alu_op    = ALU_OP_ADD;
    if (rst_n) begin
      unique case (state)
        S_FETCH: begin
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURES;
          PCWrite   = ready;
          IRWrite   = ready;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_B;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMRD: AdrSrc = 1'b1;
        S_MEMWR: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
        end
        S_EXEC_R: begin
          ALUSrcA = SRCA_RS1;
          alu_op  = ALU_OP_FUNCT;
        end
        S_EXEC_I: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          alu_op  = ALU_OP_FUNCT;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_JAL: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
        S_JALR: begin
          ALUSrcA   = SRCA_RS1;
          ALUSrcB   = SRCB_IMM;
          ImmSrc    = IMM_I;
          ResultSrc = RES_ALURES;
          PCWrite   = 1'b1;
        end
        S_LUI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_U;
        end
        S_BRANCH: begin
          ALUSrcA = SRCA_RS1;
          alu_op  = ALU_OP_SUB;
          PCWrite = take && !br_bad;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ALUCtrl      = '0;
    ALUCtrl[2:0] = alu3;
  end

  assign bus_err = bus_err_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: a driver walks each instruction through its expected
// cycle sequence, queueing expected outputs for a negedge monitor.
module tb_multicycle_ctrl;

  localparam int TMO = 15;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] RI  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LU  = 7'b0110111;

  logic       clk, rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, Zero, Lt, Ltu, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc, ALUCtrl;
  logic       bus_err, illegal;

  multicycle_ctrl #(
    .ALUCTRL_W    (3),
    .MEM_HANDSHAKE(1'b1),
    .MEM_TIMEOUT  (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .Zero     (Zero),
    .Lt       (Lt),
    .Ltu      (Ltu),
    .mem_ready(mem_ready),
    .PCWrite  (PCWrite),
    .AdrSrc   (AdrSrc),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .ResultSrc(ResultSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ImmSrc   (ImmSrc),
    .ALUCtrl  (ALUCtrl),
    .RegWrite (RegWrite),
    .bus_err  (bus_err),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic berr_m = 1'b0;
  logic ill_m  = 1'b0;
  string tag = "reset";

  function automatic logic [18:0] pk(
    logic pcw, logic adr, logic mw, logic irw, logic [1:0] res,
    logic [1:0] sa, logic [1:0] sb, logic [2:0] imm, logic [2:0] alu,
    logic rw);
    return {pcw, adr, mw, irw, res, sa, sb, imm, alu, rw, berr_m, ill_m};
  endfunction

  function automatic logic [18:0] v_fetch(logic p);
    return pk(p, 0, 0, p, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0);
  endfunction
  function automatic logic [18:0] v_idle();
    return pk(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
  endfunction
  function automatic logic [18:0] v_wb(logic [1:0] res);
    return pk(0, 0, 0, 0, res, 2'd0, 2'd0, 3'd0, 3'd0, 1);
  endfunction

  // ALU op the reference expects for an R/I arithmetic instruction.
  function automatic logic [2:0] alu_of(logic [2:0] f3, logic r, logic f7);
    case (f3)
      3'd0:    return (r && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd3:    return 3'd6;
      3'd4:    return 3'd4;
      3'd6:    return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic taken(logic [2:0] f3, logic z, logic lt, logic ltu);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return lt;
      3'd5:    return !lt;
      3'd6:    return ltu;
      default: return !ltu;
    endcase
  endfunction

  task automatic cyc(input logic rdy, input logic [18:0] e);
    mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    berr_m = 1'b0;
    ill_m  = 1'b0;
    cyc(1'($urandom), v_idle());
    rst_n = 1'b1;
  endtask

  task automatic trap_and_reset();
    repeat (3) cyc(1'($urandom), v_idle());
    do_reset();
  endtask

  // w not-ready cycles, then one ready cycle; w >= TMO ends in a timeout.
  task automatic mem_wait(input int w, input logic [18:0] wv,
                          input logic [18:0] rv, output bit to);
    for (int i = 0; i < w && i < TMO; i++) cyc(1'b0, wv);
    to = (w >= TMO);
    if (to) berr_m = 1'b1;
    else    cyc(1'b1, rv);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input logic lt,
                           input logic ltu, input int fw, input int mw);
    bit to;
    opcode = op; funct3 = f3; funct7_5 = f7;
    Zero = z; Lt = lt; Ltu = ltu;
    mem_wait(fw, v_fetch(0), v_fetch(1), to);
    if (to) begin trap_and_reset(); return; end
    cyc(1'($urandom), pk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd2, 3'd0, 0));
    case (op)
      LD, ST: begin
        cyc(1'($urandom), pk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1,
                             (op == ST) ? 3'd1 : 3'd0, 3'd0, 0));
        if (op == ST) begin
          mem_wait(mw, pk(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0),
                       pk(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0), to);
        end else begin
          mem_wait(mw, pk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0),
                       pk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0), to);
          if (!to) cyc(1'($urandom), v_wb(2'd1));
        end
        if (to) trap_and_reset();
      end
      RR, RI: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          ill_m = 1'b1;
          trap_and_reset();
        end else begin
          cyc(1'($urandom), pk(0, 0, 0, 0, 2'd0, 2'd2, (op == RR) ? 2'd0 : 2'd1,
                               3'd0, alu_of(f3, op == RR, f7), 0));
          cyc(1'($urandom), v_wb(2'd0));
        end
      end
      JL, JR, LU: begin
        if (op == JL)
          cyc(1'($urandom), pk(1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 3'd0, 0));
        else if (op == JR)
          cyc(1'($urandom), pk(1, 0, 0, 0, 2'd2, 2'd2, 2'd1, 3'd0, 3'd0, 0));
        else
          cyc(1'($urandom), pk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd4, 3'd0, 0));
        cyc(1'($urandom), v_wb(2'd0));
      end
      BR: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          cyc(1'($urandom), pk(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0));
          ill_m = 1'b1;
          trap_and_reset();
        end else begin
          cyc(1'($urandom), pk(taken(f3, z, lt, ltu), 0, 0, 0, 2'd0,
                               2'd2, 2'd0, 3'd0, 3'd1, 0));
        end
      end
      default: begin
        ill_m = 1'b1;
        trap_and_reset();
      end
    endcase
  endtask

  function automatic int pick_wait();
    int r = int'($urandom_range(0, 99));
    if (r < 80) return int'($urandom_range(0, 3));
    if (r < 87) return 14;
    if (r < 92) return TMO;
    return int'($urandom_range(4, 13));
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [18:0] e, a;
      e = exp_q.pop_front();
      a = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUCtrl, RegWrite, bus_err, illegal};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s t=%0t: outputs got %05h expected %05h", tag, $time, a, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [8];
    ops = '{LD, ST, RR, RI, JL, JR, BR, LU};
    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct3 = '0;
    funct7_5 = 1'b0; Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
    @(posedge clk);
    #1;
    tag = "reset";
    cyc(1'b1, v_idle());
    cyc(1'b0, v_idle());
    rst_n = 1'b1;

    tag = "add";   run_instr(RR, 3'd0, 1'b0, 0, 0, 0, 0, 0);
    tag = "sub";   run_instr(RR, 3'd0, 1'b1, 0, 0, 0, 0, 0);
    tag = "lw";    run_instr(LD, 3'd2, 1'b0, 0, 0, 0, 0, 3);
    tag = "bltu";  run_instr(BR, 3'd6, 1'b0, 0, 0, 1, 0, 0);
    tag = "bge";   run_instr(BR, 3'd5, 1'b0, 0, 1, 0, 0, 0);
    tag = "br010"; run_instr(BR, 3'd2, 1'b0, 1, 1, 1, 0, 0);
    tag = "sw_to"; run_instr(ST, 3'd2, 1'b0, 0, 0, 0, 0, TMO);
    tag = "op0";   run_instr(7'd0, 3'd0, 1'b0, 0, 0, 0, 0, 0);
    tag = "sll";   run_instr(RR, 3'd1, 1'b0, 0, 0, 0, 0, 0);
    tag = "fet_to"; run_instr(RI, 3'd0, 1'b0, 0, 0, 0, TMO, 0);

    // Store interrupted by reset while MemWrite is asserted.
    tag = "sw_rst";
    opcode = ST; funct3 = 3'd2;
    cyc(1'b1, v_fetch(1));
    cyc(1'b0, pk(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd2, 3'd0, 0));
    cyc(1'b0, pk(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 3'd0, 0));
    cyc(1'b0, pk(0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
    cyc(1'b0, pk(0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
    do_reset();
    tag = "after_rst"; run_instr(RI, 3'd4, 1'b0, 0, 0, 0, 0, 0);

    tag = "random";
    for (int n = 0; n < 250; n++) begin
      int k = int'($urandom_range(0, 9));
      logic [6:0] op = (k < 8) ? ops[k] : 7'($urandom);
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), pick_wait(), pick_wait());
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
